// File: rtl/multi_synch_if.sv
// Bundles the raw inputs, edge mode and conditioned outputs of multi_synch.
interface multi_synch_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0] asynch_in;
  logic [1:0]          edge_mode;
  logic [CHANNELS-1:0] level_out;
  logic [CHANNELS-1:0] pulse_out;
  logic                any_pulse;

  modport master (
    output asynch_in, edge_mode,
    input  level_out, pulse_out, any_pulse
  );

  modport slave (
    input  asynch_in, edge_mode,
    output level_out, pulse_out, any_pulse
  );
endinterface

// File: rtl/multi_synch.sv
// Multi-channel input conditioner: per-channel synchroniser chain, glitch
// filter requiring FILTER consecutive disagreeing cycles, and edge pulse.
module multi_synch #(
  parameter int unsigned         CHANNELS = 4,
  parameter int unsigned         STAGES   = 2,
  parameter int unsigned         FILTER   = 4,
  parameter logic [CHANNELS-1:0] RST_VAL  = '0
) (
  input logic           clk,
  input logic           rst_n,
  multi_synch_if.slave  bus
);

  localparam int unsigned      CNT_W    = $clog2(FILTER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

  logic [STAGES-1:0]   sync_q [CHANNELS];
  logic [STAGES-1:0]   sync_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CNT_W-1:0]    cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] sync_out;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] pulse_q, pulse_d;

  // Only sync[0] sees the raw input; the rest is a plain shift chain.
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      sync_d[c]   = {sync_q[c][STAGES-2:0], bus.asynch_in[c]};
      sync_out[c] = sync_q[c][STAGES-1];
    end
  end

  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      cnt_d[c] = '0;
      if (sync_out[c] != level_q[c]) begin
        if (cnt_q[c] == CNT_LAST) begin
          level_d[c] = sync_out[c];
          // New level 1 is a rising edge (mode bit 0), 0 is falling (bit 1).
          pulse_d[c] = sync_out[c] ? bus.edge_mode[0] : bus.edge_mode[1];
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        sync_q[c] <= {STAGES{RST_VAL[c]}};
        cnt_q[c]  <= '0;
      end
      level_q <= RST_VAL;
      pulse_q <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        sync_q[c] <= sync_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.level_out = level_q;
  assign bus.pulse_out = pulse_q;
  assign bus.any_pulse = |pulse_q;

endmodule

// File: tb/tb_multi_synch.sv
// Bench for multi_synch: two differently parameterised instances checked
// against a sliding-window behavioural model plus directed timing checks.
module tb_multi_synch;

  logic       clk;
  logic       rst_n;
  logic [3:0] in0;
  logic [3:0] in1;
  logic [1:0] mode;

  int vectors    = 0;
  int miscompares = 0;

  multi_synch_if #(.CHANNELS(4)) if0 ();
  multi_synch_if #(.CHANNELS(4)) if1 ();

  assign if0.asynch_in = in0;
  assign if0.edge_mode = mode;
  assign if1.asynch_in = in1;
  assign if1.edge_mode = mode;

  multi_synch #(.CHANNELS(4), .STAGES(2), .FILTER(4), .RST_VAL(4'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave)
  );
  multi_synch #(.CHANNELS(4), .STAGES(3), .FILTER(2), .RST_VAL(4'hF)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a new level is accepted when the last FILTER
  // synchronised samples (raw input delayed STAGES edges) all differ from it.
  int       st [2] = '{2, 3};
  int       fi [2] = '{4, 2};
  bit [3:0] rv [2] = '{4'h0, 4'hF};

  bit [15:0] hist    [2][4];
  bit [3:0]  m_level [2];
  bit [3:0]  m_pulse [2];

  function automatic bit window_differs(bit [15:0] h, int s, int f, bit lvl);
    for (int j = 0; j < f; j++)
      if (h[s-1+j] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_level[i] <= rv[i];
        m_pulse[i] <= '0;
        for (int c = 0; c < 4; c++) hist[i][c] <= {16{rv[i][c]}};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < 4; c++) begin
          hist[i][c] <= {hist[i][c][14:0], (i == 0) ? in0[c] : in1[c]};
          if (window_differs(hist[i][c], st[i], fi[i], m_level[i][c])) begin
            m_level[i][c] <= ~m_level[i][c];
            m_pulse[i][c] <= m_level[i][c] ? mode[1] : mode[0];
          end else begin
            m_pulse[i][c] <= 1'b0;
          end
        end
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; in0 = 4'h0; in1 = 4'hF; mode = 2'b11;
    repeat (3) @(negedge clk);
    vectors++;
    if (if0.level_out !== 4'h0 || if0.pulse_out !== 4'h0 || if0.any_pulse !== 1'b0 ||
        if1.level_out !== 4'hF || if1.pulse_out !== 4'h0 || if1.any_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold lvl0=%b lvl1=%b p0=%b p1=%b want 0000/1111/0/0",
               if0.level_out, if1.level_out, if0.pulse_out, if1.pulse_out);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      vectors++;
      if (if0.level_out !== 4'h0 || if0.pulse_out !== 4'h0 ||
          if1.level_out !== 4'hF || if1.pulse_out !== 4'h0 ||
          (if0.any_pulse | if1.any_pulse) !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle k=%0d lvl0=%b lvl1=%b p0=%b p1=%b want 0000/1111/0/0",
                 k, if0.level_out, if1.level_out, if0.pulse_out, if1.pulse_out);
      end
    end
  endtask

  task automatic test_latency;
    mode = 2'b01;
    in0[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      vectors++;
      if (if0.level_out[0] !== (k >= 6) || if0.pulse_out[0] !== (k == 6)) begin
        miscompares++;
        $display("FAIL latency_rise k=%0d level=%b pulse=%b want %b/%b",
                 k, if0.level_out[0], if0.pulse_out[0], k >= 6, k == 6);
      end
    end
    in0[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      vectors++;
      if (if0.level_out[0] !== (k < 6) || if0.pulse_out[0] !== 1'b0 ||
          if1.pulse_out !== m_pulse[1] || if1.level_out !== m_level[1]) begin
        miscompares++;
        $display("FAIL latency_fall k=%0d level=%b pulse=%b want %b/0",
                 k, if0.level_out[0], if0.pulse_out[0], k < 6);
      end
    end
  endtask

  task automatic test_glitch;
    mode = 2'b11;
    in0[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      vectors++;
      if (if0.level_out[1] !== 1'b0 || if0.pulse_out[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch_reject k=%0d level=%b pulse=%b want 0/0",
                 k, if0.level_out[1], if0.pulse_out[1]);
      end
      if (k == 3) in0[1] = 1'b0;
    end
    in0[1] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      vectors++;
      if (if0.level_out[1] !== (k >= 6 && k < 10) ||
          if0.pulse_out[1] !== (k == 6 || k == 10)) begin
        miscompares++;
        $display("FAIL glitch_accept k=%0d level=%b pulse=%b want %b/%b",
                 k, if0.level_out[1], if0.pulse_out[1], k >= 6 && k < 10, k == 6 || k == 10);
      end
      if (k == 4) in0[1] = 1'b0;
    end
  endtask

  task automatic test_modes;
    int n;
    int pcount;
    int want;
    n = 200;
    for (int m = 0; m < 4; m++) begin
      mode   = 2'(m);
      pcount = 0;
      for (int r = 0; r < n + 2; r++) begin
        for (int t = 0; t < 10; t++) begin
          in0[2] = (r < n) && (t < 5);
          in1[2] = (r < n) && (t < 5);
          @(negedge clk);
          pcount += int'(if0.pulse_out[2]);
          vectors += 2;
          if (if0.level_out !== m_level[0] || if0.pulse_out !== m_pulse[0] ||
              if0.any_pulse !== (|m_pulse[0])) begin
            miscompares++;
            $display("FAIL modes_dut0 m=%0d level=%b/%b pulse=%b/%b",
                     m, if0.level_out, m_level[0], if0.pulse_out, m_pulse[0]);
          end
          if (if1.level_out !== m_level[1] || if1.pulse_out !== m_pulse[1] ||
              if1.any_pulse !== (|m_pulse[1])) begin
            miscompares++;
            $display("FAIL modes_dut1 m=%0d level=%b/%b pulse=%b/%b",
                     m, if1.level_out, m_level[1], if1.pulse_out, m_pulse[1]);
          end
        end
      end
      want = n * (m % 2 + m / 2);
      vectors++;
      if (pcount !== want) begin
        miscompares++;
        $display("FAIL modes_count mode=%0d got %0d pulses want %0d", m, pcount, want);
      end
    end
  endtask

  task automatic test_multi_mode_switch;
    mode = 2'b11;
    in0  = 4'b1001;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      vectors++;
      if (if0.pulse_out !== ((k == 6) ? 4'b1001 : 4'b0000) || if0.any_pulse !== (k == 6)) begin
        miscompares++;
        $display("FAIL multi_edge k=%0d pulse=%b any=%b want %b/%b",
                 k, if0.pulse_out, if0.any_pulse, (k == 6) ? 4'b1001 : 4'b0000, k == 6);
      end
    end
    for (int k = 0; k < 20; k++) begin
      mode = 2'($urandom_range(3));
      @(negedge clk);
      vectors++;
      if (if0.pulse_out !== 4'h0 || if1.pulse_out !== 4'h0 ||
          if0.any_pulse !== 1'b0 || if1.any_pulse !== 1'b0 || if0.level_out !== 4'b1001) begin
        miscompares++;
        $display("FAIL mode_switch k=%0d p0=%b p1=%b lvl0=%b want 0000/0000/1001",
                 k, if0.pulse_out, if1.pulse_out, if0.level_out);
      end
    end
  endtask

  task automatic test_reset_mid;
    int pcount [4];
    mode = 2'b11;
    in0  = 4'b1010;
    repeat (10) @(negedge clk);
    in0 = 4'b0101;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (if0.level_out !== 4'h0 || if0.pulse_out !== 4'h0 || if0.any_pulse !== 1'b0 ||
        if1.level_out !== 4'hF || if1.pulse_out !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_mid lvl0=%b p0=%b lvl1=%b p1=%b want 0000/0000/1111/0000",
               if0.level_out, if0.pulse_out, if1.level_out, if1.pulse_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pcount = '{0, 0, 0, 0};
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) pcount[c] += int'(if0.pulse_out[c]);
      vectors++;
      if (if1.level_out !== m_level[1] || if1.pulse_out !== m_pulse[1]) begin
        miscompares++;
        $display("FAIL reset_mid_dut1 k=%0d level=%b/%b pulse=%b/%b",
                 k, if1.level_out, m_level[1], if1.pulse_out, m_pulse[1]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (pcount[c] !== int'(in0[c] ^ rv[0][c])) begin
        miscompares++;
        $display("FAIL reset_mid_edges ch=%0d got %0d pulses want %0d",
                 c, pcount[c], int'(in0[c] ^ rv[0][c]));
      end
    end
    vectors++;
    if (if0.level_out !== in0) begin
      miscompares++;
      $display("FAIL reset_mid_level got %b want %b", if0.level_out, in0);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 3000; k++) begin
      if (k % 50 == 0) mode = 2'($urandom_range(3));
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(5) == 0) in0[c] = ~in0[c];
        if ($urandom_range(3) == 0) in1[c] = ~in1[c];
      end
      @(negedge clk);
      vectors += 2;
      if (if0.level_out !== m_level[0] || if0.pulse_out !== m_pulse[0] ||
          if0.any_pulse !== (|m_pulse[0])) begin
        miscompares++;
        $display("FAIL random_dut0 k=%0d level=%b/%b pulse=%b/%b",
                 k, if0.level_out, m_level[0], if0.pulse_out, m_pulse[0]);
      end
      if (if1.level_out !== m_level[1] || if1.pulse_out !== m_pulse[1] ||
          if1.any_pulse !== (|m_pulse[1])) begin
        miscompares++;
        $display("FAIL random_dut1 k=%0d level=%b/%b pulse=%b/%b",
                 k, if1.level_out, m_level[1], if1.pulse_out, m_pulse[1]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in0   = 4'h0;
    in1   = 4'hF;
    mode  = 2'b11;
    test_reset();
    test_latency();
    test_glitch();
    test_modes();
    test_multi_mode_switch();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
